bus_sync_tx: RTL and testbench
==============================

BUS_SYNC_TX -- requirements
Module: bus_sync_tx

Interface
REQ-001 Parameter P_WIDTH, default 8: width of the transferred data word.
REQ-002 Parameter NUM_STAGES, default 2, minimum 2: number of flops in the ack_in synchronizer chain.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 src_valid  input  1  source offers src_data this cycle.
REQ-006 src_data  input  P_WIDTH  word to transfer.
REQ-007 src_ready  output  1  block can accept a word this cycle.
REQ-008 data_out  output  P_WIDTH  registered word presented to the destination domain; stable while a transfer is pending.
REQ-009 req_out  output  1  registered request toggle (2-phase) to the destination domain.
REQ-010 ack_in  input  1  asynchronous acknowledge toggle from the destination domain.
REQ-011 done  output  1  one-cycle pulse marking completion of a transfer.
REQ-012 proto_err  output  1  sticky flag for an unexpected ack toggle.

Function
REQ-013 The block SHALL implement the source side of a 2-phase req/ack bus synchronizer with FSM states IDLE and WAIT_ACK.
REQ-014 ack_in SHALL pass through exactly NUM_STAGES flops clocked by clk; only the last stage (ack_sync) SHALL be used by any logic.
REQ-015 src_ready SHALL be 1 in IDLE and 0 in WAIT_ACK; it is decoded from the state register only.
REQ-016 Accept = src_valid & src_ready at a rising edge; on accept: data_out <= src_data, req_out <= ~req_out, state <= WAIT_ACK.
REQ-017 data_out and req_out SHALL change only on accept or on reset; data_out SHALL remain stable throughout WAIT_ACK.
REQ-018 In WAIT_ACK, when ack_sync == req_out, the next edge SHALL set state <= IDLE and done <= 1 for exactly one cycle.
REQ-019 Timing: if ack_in toggles and is stable before edge E0, the WAIT_ACK->IDLE transition SHALL occur at edge E0+NUM_STAGES, with done high in the cycle that follows.
REQ-020 Min accept-to-accept spacing SHALL be bounded only by ack round-trip; a new word MAY be accepted in the same cycle done is high.
REQ-021 src_valid and src_data during WAIT_ACK SHALL be ignored; no word SHALL be lost or duplicated.
REQ-022 In IDLE, ack_sync != req_out SHALL set proto_err <= 1; proto_err stays 1 until reset; transfers continue normally.
REQ-023 In WAIT_ACK, ack_sync toggling back before matching is impossible in 2-phase protocol and needs no special handling.
REQ-024 done SHALL never be high in two consecutive cycles.

Reset
REQ-025 On rst=1 at a rising edge: state <= IDLE, req_out <= 0, data_out <= 0, done <= 0, proto_err <= 0, all synchronizer stages <= 0.
REQ-026 src_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 Reset during WAIT_ACK SHALL abandon the transfer; the destination side must be reset concurrently (system requirement).
REQ-028 rst SHALL take priority over accept and over ack detection in the same cycle.

Verification
REQ-029 Reset, then idle 5 cycles -> src_ready=1, req_out=0, data_out=0x00, done=0, proto_err=0.
REQ-030 Accept 0xA5; ack_in toggles 3 cycles later -> req_out=1 and data_out=0xA5 one cycle after accept, src_ready=0 until done, done pulse exactly NUM_STAGES+1 cycles after ack_in toggles (held 1 cycle).
REQ-031 Back-to-back 0x11, 0x22, 0x33 with src_valid held high, ack loopback delayed 4 cycles -> req_out toggles 1,0,1; each word appears once on data_out in order; second accept in the done cycle.
REQ-032 src_data changes to 0xFF during WAIT_ACK -> data_out stays at accepted value, no extra req_out toggle.
REQ-033 Toggle ack_in while IDLE -> proto_err=1 after NUM_STAGES+1 edges and stays 1; next transfer of 0x3C still completes with done.
REQ-034 Assert rst during WAIT_ACK -> next cycle req_out=0, data_out=0, state IDLE, src_ready=1, no done pulse.

Source files
------------

// File: rtl/bus_sync_tx.sv
// Source side of a 2-phase req/ack bus synchronizer.
// A word is captured into data_out and announced by toggling req_out. The
// destination answers by toggling ack_in to match req_out. ack_in is brought
// into this clock domain through a NUM_STAGES flop chain, and only the last
// stage is used by any logic.
module bus_sync_tx #(
  parameter int P_WIDTH    = 8,
  parameter int NUM_STAGES = 2   // must be at least 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_valid,
  input  logic [P_WIDTH-1:0] src_data,
  output logic               src_ready,
  output logic [P_WIDTH-1:0] data_out,
  output logic               req_out,
  input  logic               ack_in,
  output logic               done,
  output logic               proto_err
);

  // A 1-bit state register keeps the encoding compatible with older tools.
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [P_WIDTH-1:0]    data_q, data_d;
  logic                  req_q, req_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic                  ack_sync;
  logic                  accept;

  // Synchronizer next value: stage 0 samples the asynchronous ack_in,
  // each later stage takes the one before it.
  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], ack_in};
  end

  // Synchronizer flops; every stage clears on reset so a restart never sees
  // a stale acknowledge from before the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Only the final synchronizer stage is considered safe to use.
  assign ack_sync = sync_q[NUM_STAGES-1];

  // Ready is decoded purely from the state register so it never depends
  // combinationally on src_valid or ack_in.
  assign src_ready = (state_q == ST_IDLE);
  assign accept    = src_valid & src_ready;

  // Next-state logic: capture and toggle on accept, finish when the
  // synchronized acknowledge catches up with the request.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        // With no transfer outstanding ack must already match req; any
        // difference means the destination toggled on its own.
        if (ack_sync != req_q) begin
          err_d = 1'b1;
        end
        if (accept) begin
          data_d  = src_data;
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // src_valid/src_data are ignored here; data_out is held steady.
        // The done pulse is one cycle long because the next state is IDLE.
        if (ack_sync == req_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over accept and ack detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign req_out   = req_q;
  assign done      = done_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_bus_sync_tx.sv
// Directed bench for bus_sync_tx with NUM_STAGES=2, P_WIDTH=8.
module tb_bus_sync_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       src_ready;
  logic [7:0] data_out;
  logic       req_out;
  logic       ack_in;
  logic       done;
  logic       proto_err;

  // Destination model: either a manual ack level or req_out delayed 4 cycles.
  logic       ack_man = 1'b0;
  logic       loop_en = 1'b0;
  logic [3:0] req_dly = 4'b0000;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) req_dly <= {req_dly[2:0], req_out};
  assign ack_in = loop_en ? req_dly[3] : ack_man;

  bus_sync_tx #(.P_WIDTH(8), .NUM_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .data_out  (data_out),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .done      (done),
    .proto_err (proto_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait up to max_cyc edges for done; a timeout counts as a failure.
  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [7:0] words [3];
    logic [7:0] last_data;
    logic       exp_req;
    logic       was_ready;
    logic       was_done;
    int         idx;

    // Reset, then 5 idle cycles
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    check("rst_src_ready", {31'd0, src_ready}, 32'd1);
    check("rst_req_out",   {31'd0, req_out},   32'd0);
    check("rst_data_out",  {24'd0, data_out},  32'h00);
    check("rst_done",      {31'd0, done},      32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);

    // Single transfer of 0xA5, ack toggles 3 cycles after accept
    src_valid = 1'b1; src_data = 8'hA5;
    step();
    src_valid = 1'b0;
    check("a5_req_out",   {31'd0, req_out},   32'd1);
    check("a5_data_out",  {24'd0, data_out},  32'hA5);
    check("a5_ready_low", {31'd0, src_ready}, 32'd0);
    step(); step();
    ack_man = 1'b1;
    step();
    check("a5_done_e0",   {31'd0, done},      32'd0);
    check("a5_ready_e0",  {31'd0, src_ready}, 32'd0);
    step();
    check("a5_done_e1",   {31'd0, done},      32'd0);
    step();
    check("a5_done_pulse", {31'd0, done},     32'd1);
    check("a5_ready_back", {31'd0, src_ready}, 32'd1);
    check("a5_data_hold",  {24'd0, data_out},  32'hA5);
    step();
    check("a5_done_once",  {31'd0, done},     32'd0);
    check("a5_no_err",     {31'd0, proto_err}, 32'd0);

    // src_data changes to 0xFF while waiting: must be ignored
    src_valid = 1'b1; src_data = 8'h77;
    step();
    src_data = 8'hFF;
    check("ign_req_out", {31'd0, req_out}, 32'd0);
    step(); step();
    check("ign_data_hold", {24'd0, data_out}, 32'h77);
    check("ign_req_hold",  {31'd0, req_out},  32'd0);
    src_valid = 1'b0;
    ack_man = 1'b0;
    wait_done("ign_done", 10);
    check("ign_data_final", {24'd0, data_out}, 32'h77);
    step();

    // Back-to-back 0x11, 0x22, 0x33 with 4-cycle ack loopback
    repeat (5) step();
    loop_en = 1'b1;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    idx = 0;
    exp_req = 1'b1;
    last_data = data_out;
    src_valid = 1'b1; src_data = words[0];
    for (int cyc = 0; cyc < 200 && idx < 3; cyc++) begin
      was_ready = src_ready;
      was_done  = done;
      step();
      check("b2b_done_consec", {31'd0, was_done & done}, 32'd0);
      if (was_ready) begin
        check($sformatf("b2b_data_%0d", idx), {24'd0, data_out}, {24'd0, words[idx]});
        check($sformatf("b2b_req_%0d", idx),  {31'd0, req_out},  {31'd0, exp_req});
        if (idx > 0) check($sformatf("b2b_in_done_%0d", idx), {31'd0, was_done}, 32'd1);
        exp_req   = ~exp_req;
        last_data = data_out;
        idx++;
        if (idx < 3) src_data = words[idx];
        else src_valid = 1'b0;
      end else begin
        check("b2b_data_stable", {24'd0, data_out}, {24'd0, last_data});
      end
    end
    check("b2b_all_accepted", idx, 3);
    wait_done("b2b_last_done", 20);
    check("b2b_final_req", {31'd0, req_out}, 32'd1);
    repeat (6) step();
    ack_man = req_out;
    loop_en = 1'b0;
    step();

    // Spurious ack toggle while idle -> sticky proto_err
    ack_man = ~ack_man;
    step(); step();
    check("err_not_yet", {31'd0, proto_err}, 32'd0);
    step();
    check("err_set",     {31'd0, proto_err}, 32'd1);
    repeat (3) step();
    check("err_sticky",  {31'd0, proto_err}, 32'd1);
    src_valid = 1'b1; src_data = 8'h3C;
    step();
    src_valid = 1'b0;
    check("err_3c_data", {24'd0, data_out}, 32'h3C);
    wait_done("err_3c_done", 10);
    check("err_still",   {31'd0, proto_err}, 32'd1);
    step();

    // Reset during WAIT_ACK abandons the transfer
    src_valid = 1'b1; src_data = 8'h99;
    step();
    src_valid = 1'b0;
    check("wrst_pending", {31'd0, src_ready}, 32'd0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("wrst_req_out",   {31'd0, req_out},   32'd0);
    check("wrst_data_out",  {24'd0, data_out},  32'h00);
    check("wrst_src_ready", {31'd0, src_ready}, 32'd1);
    check("wrst_done",      {31'd0, done},      32'd0);
    check("wrst_proto_err", {31'd0, proto_err}, 32'd0);
    ack_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("wrst_no_done", {31'd0, done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
